// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package dmem_pkg;

    // Responder FSM: accept a request, count wait states, present the response.
    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    // Wait-state counter width; it covers LAT values 0..15.
    localparam int CNT_W = 4;

    // Byte lanes per 32-bit word.
    localparam int LANES = 4;

    // Word-index width for a storage array of the given depth.
    function automatic int idx_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage with per-byte write enables and a registered read port.
// Latency: read data appears one cycle after en_i; writes land on the same edge.
// Backpressure: none; one access per enabled cycle.
//
// Ports:
//   clk      clock
//   en_i     access strobe (one commit)
//   wen_i    byte-lane write enables, applied only while en_i=1
//   idx_i    word index
//   wdata_i  write data
//   rdata_o  word read on the last enabled edge (value before that edge's write)
module dmem_array
    import dmem_pkg::*;
#(
    parameter  int DEPTH_WORDS = 1024,
    localparam int IW          = idx_width(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             en_i,
    input  logic [LANES-1:0] wen_i,
    input  logic [IW-1:0]    idx_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o
);

    // Contents are deliberately never reset.
    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            for (int b = 0; b < LANES; b++) begin
                if (wen_i[b]) begin
                    mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory target for the core's MEM stage: word storage, byte-lane stores, programmable wait states.
// Latency: request accepted at edge N commits at edge N+1+LAT; response is valid from then until taken.
// Backpressure: single outstanding transaction; req_ready_o is low from acceptance until the response handshake.
//
// Ports:
//   clk, rst                      clock and synchronous active-high reset
//   req_valid_i / req_ready_o     request handshake
//   req_we_i, req_addr_i,
//   req_wdata_i, req_be_i         store flag, byte address, store data, byte enables
//   rsp_valid_o / rsp_ready_i     response handshake
//   rsp_rdata_o                   load data (0 for stores, out-of-range and errored accesses)
//   rsp_err_o                     misaligned / out-of-range flag, present only with
//                                 DMEM_RESPONDER_ALIGN_CHECK_EN defined
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LAT         = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_we_i,
    input  logic [31:0]      req_addr_i,
    input  logic [31:0]      req_wdata_i,
    input  logic [LANES-1:0] req_be_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [31:0]      rsp_rdata_o
`ifdef DMEM_RESPONDER_ALIGN_CHECK_EN
    ,
    output logic             rsp_err_o
`endif
);

    localparam int IW = idx_width(DEPTH_WORDS);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             rsp_valid_q;
    // rsp_rdata_o shows array data only after an in-range, error-free load.
    logic             ld_ok_q;

    // Captured request; only the word address is kept.
    logic             we_q;
    logic [29:0]      waddr_q;
    logic [31:0]      wdata_q;
    logic [LANES-1:0] be_q;

    logic [29:0]      word_off;
    logic             in_range;
    logic             bad;
    logic             commit;
    logic [31:0]      arr_rdata;

`ifdef DMEM_RESPONDER_ALIGN_CHECK_EN
    logic             mis_q;
    logic             err_q;
`else
    logic             unused_addr_lsb;
    assign unused_addr_lsb = ^req_addr_i[1:0];
`endif

    // BASE_ADDR is word aligned, so the offset can be formed on word addresses.
    assign word_off = waddr_q - BASE_ADDR[31:2];
    assign in_range = (waddr_q >= BASE_ADDR[31:2]) && (word_off[29:IW] == '0);

`ifdef DMEM_RESPONDER_ALIGN_CHECK_EN
    assign bad = ~in_range | mis_q;
`else
    assign bad = ~in_range;
`endif

    // Commit edge: last wait cycle. Reset on that edge drops the store.
    assign commit = (state_q == WAIT) && (cnt_q == '0) && !rst;

    assign req_ready_o = (state_q == IDLE) && !rst;

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk     (clk),
        .en_i    (commit && !bad),
        .wen_i   (we_q ? be_q : '0),
        .idx_i   (word_off[IW-1:0]),
        .wdata_i (wdata_q),
        .rdata_o (arr_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            ld_ok_q     <= 1'b0;
`ifdef DMEM_RESPONDER_ALIGN_CHECK_EN
            err_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        we_q    <= req_we_i;
                        waddr_q <= req_addr_i[31:2];
                        wdata_q <= req_wdata_i;
                        be_q    <= req_be_i;
`ifdef DMEM_RESPONDER_ALIGN_CHECK_EN
                        // Partial-lane stores may legitimately use the low address bits.
                        mis_q   <= (req_addr_i[1:0] != 2'b00) &&
                                   (!req_we_i || (req_be_i == 4'hF));
`endif
                        // Counting LAT..0 puts the commit on edge N+1+LAT.
                        cnt_q   <= CNT_W'(LAT);
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        ld_ok_q     <= !we_q && !bad;
`ifdef DMEM_RESPONDER_ALIGN_CHECK_EN
                        err_q       <= bad;
`endif
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    // Both terms only change on a commit, so the data holds through the response.
    assign rsp_rdata_o = ld_ok_q ? arr_rdata : 32'h0;
`ifdef DMEM_RESPONDER_ALIGN_CHECK_EN
    assign rsp_err_o   = err_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances (LAT=2; LAT=0 with 16 words; LAT=15 at base 0x1000).
// Latency: n/a.
// Backpressure: rsp_ready_i is held or randomly throttled by the bench.
module tb_dmem_responder;

`ifdef DMEM_RESPONDER_ALIGN_CHECK_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        rv    [3];
    logic        rr    [3];
    logic        we    [3];
    logic        vld   [3];
    logic        rdy   [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [31:0] rdata [3];
    logic [3:0]  be    [3];
`ifdef DMEM_RESPONDER_ALIGN_CHECK_EN
    logic        err   [3];
    logic        last_err;
`endif

    int nvec = 0;
    int nmis = 0;
    int acc_cnt [3] = '{0, 0, 0};
    int rsp_cnt [3] = '{0, 0, 0};
    int issued  [3] = '{0, 0, 0};

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_responder #(
            .DEPTH_WORDS (g == 1 ? 16 : 1024),
            .LAT         (g == 0 ? 2 : (g == 1 ? 0 : 15)),
            .BASE_ADDR   (g == 2 ? 32'h0000_1000 : 32'h0000_0000)
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .req_valid_i (rv[g]),
            .req_ready_o (rr[g]),
            .req_we_i    (we[g]),
            .req_addr_i  (addr[g]),
            .req_wdata_i (wdata[g]),
            .req_be_i    (be[g]),
            .rsp_valid_o (vld[g]),
            .rsp_ready_i (rdy[g]),
            .rsp_rdata_o (rdata[g])
`ifdef DMEM_RESPONDER_ALIGN_CHECK_EN
            ,
            .rsp_err_o   (err[g])
`endif
        );
    end

    // Handshake counters per instance.
    always @(posedge clk) begin
        for (int u = 0; u < 3; u++) begin
            if (rv[u] && rr[u])   acc_cnt[u] <= acc_cnt[u] + 1;
            if (vld[u] && rdy[u]) rsp_cnt[u] <= rsp_cnt[u] + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
        end
    endtask

    // One request/response. cyc = edges from acceptance to the edge that raised rsp_valid_o.
    task automatic xact(input int u, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, input bit thr, output logic [31:0] rd, output int cyc);
        int n;
        bit done;
        rd  = '0;
        cyc = -1;
        @(negedge clk);
        rv[u] = 1'b1; we[u] = w; addr[u] = a; wdata[u] = d; be[u] = b;
        n = 0;
        while (!rr[u] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rr[u]) begin
            rv[u] = 1'b0;
            chk("req_timeout", 32'(n), 32'd0);
            return;
        end
        @(posedge clk);
        #1 rv[u] = 1'b0;
        issued[u]++;
        @(negedge clk);
        cyc = 0;
        while (!vld[u] && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        if (!vld[u]) begin
            chk("rsp_timeout", 32'(cyc), 32'd0);
            cyc = -1;
            return;
        end
        rd = rdata[u];
`ifdef DMEM_RESPONDER_ALIGN_CHECK_EN
        last_err = err[u];
`endif
        n    = 0;
        done = 1'b0;
        while (!done) begin
            rdy[u] = (thr && n < 40) ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk);
            done = rdy[u];
            #1 rdy[u] = 1'b0;
            if (!done) begin
                @(negedge clk);
                chk("hold_vld", 32'(vld[u]), 32'd1);
                chk("hold_dat", rdata[u], rd);
                n++;
            end
        end
    endtask

    task automatic op(input int u, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] b, input logic [31:0] exp_rd, input int exp_cyc,
                      input string tag);
        logic [31:0] rd;
        int cyc;
        xact(u, w, a, d, b, 1'b0, rd, cyc);
        chk({tag, "_lat"}, 32'(cyc), 32'(exp_cyc));
        chk({tag, "_rd"}, rd, exp_rd);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] model [4];
        logic [31:0] rd_v;
        logic [31:0] d_v;
        logic [3:0]  b_v;
        logic        w_v;
        int          cyc_v;
        int          seen;
        int          a0;
        int          idx;

        for (int u = 0; u < 3; u++) begin
            rv[u] = 1'b0; rdy[u] = 1'b0; we[u] = 1'b0;
            addr[u] = '0; wdata[u] = '0; be[u] = '0;
        end

        // Reset values.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_rdy",   32'(rr[0]),  32'd0);
        chk("rst_vld",   32'(vld[0]), 32'd0);
        chk("rst_rdata", rdata[0],    32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_rdy", 32'(rr[0]), 32'd1);

        // LAT=2: full store then load; byte lanes; be=0; low address bits.
        op(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0,        3, "a_st10");
        op(0, 1'b0, 32'h10, 32'h0,        4'h0, 32'hDEADBEEF, 3, "a_ld10");
        op(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 32'h0,        3, "a_st20");
        op(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'h5, 32'h0,        3, "a_stbe");
        op(0, 1'b0, 32'h20, 32'h0,        4'h0, 32'h11BB33DD, 3, "a_ldbe");
        op(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 32'h0,        3, "a_be0");
        op(0, 1'b0, 32'h20, 32'h0,        4'h0, 32'h11BB33DD, 3, "a_ldbe0");
        op(0, 1'b0, 32'h23, 32'h0,        4'h0, ERR_ON ? 32'h0 : 32'h11BB33DD, 3, "a_ld23");
`ifdef DMEM_RESPONDER_ALIGN_CHECK_EN
        chk("a_ld23_err", 32'(last_err), 32'd1);
`endif

        // Reset while a store waits: no response, old data kept.
        op(0, 1'b1, 32'h40, 32'h0, 4'hF, 32'h0, 3, "a_st40");
        @(negedge clk);
        rv[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h40; wdata[0] = 32'h12345678; be[0] = 4'hF;
        @(posedge clk);
        #1 rv[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (vld[0]) seen++;
        end
        chk("a_rst_norsp", 32'(seen), 32'd0);
        op(0, 1'b0, 32'h40, 32'h0, 4'h0, 32'h0, 3, "a_ld40");

        // LAT=0: response held under rsp_ready_i=0, no acceptance meanwhile.
        op(1, 1'b1, 32'h8, 32'hCAFEF00D, 4'hF, 32'h0, 1, "b_st8");
        @(negedge clk);
        rv[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h8; be[1] = 4'h0;
        @(posedge clk);
        #1 rv[1] = 1'b0;
        issued[1]++;
        @(negedge clk);
        cyc_v = 0;
        while (!vld[1] && cyc_v < 10) begin
            @(negedge clk);
            cyc_v++;
        end
        chk("b_hold_lat", 32'(cyc_v), 32'd1);
        rd_v = rdata[1];
        chk("b_hold_rd", rd_v, 32'hCAFEF00D);
        a0 = acc_cnt[1];
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                rv[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h8; wdata[1] = 32'h0; be[1] = 4'hF;
            end
            @(negedge clk);
            rv[1] = 1'b0;
            chk("b_hold_vld", 32'(vld[1]), 32'd1);
            chk("b_hold_dat", rdata[1],    rd_v);
            chk("b_hold_rdy", 32'(rr[1]),  32'd0);
        end
        chk("b_no_accept", 32'(acc_cnt[1]), 32'(a0));
        rdy[1] = 1'b1;
        @(posedge clk);
        #1 rdy[1] = 1'b0;
        op(1, 1'b0, 32'h8, 32'h0, 4'h0, 32'hCAFEF00D, 1, "b_ld8");

        // DEPTH_WORDS=16: range boundary.
        op(1, 1'b1, 32'h0,  32'h5A5A5A5A, 4'hF, 32'h0, 1, "b_st0");
        op(1, 1'b1, 32'h3C, 32'h01020304, 4'hF, 32'h0, 1, "b_st3c");
        op(1, 1'b0, 32'h3C, 32'h0, 4'h0, 32'h01020304, 1, "b_ld3c");
        op(1, 1'b0, 32'h40, 32'h0, 4'h0, 32'h0, 1, "b_ld40");
`ifdef DMEM_RESPONDER_ALIGN_CHECK_EN
        chk("b_ld40_err", 32'(last_err), 32'd1);
`endif
        op(1, 1'b1, 32'h40, 32'hFFFFFFFF, 4'hF, 32'h0, 1, "b_st40");
`ifdef DMEM_RESPONDER_ALIGN_CHECK_EN
        chk("b_st40_err", 32'(last_err), 32'd1);
`endif
        op(1, 1'b0, 32'h0, 32'h0, 4'h0, 32'h5A5A5A5A, 1, "b_ld0");
        op(1, 1'b0, 32'h3, 32'h0, 4'h0, ERR_ON ? 32'h0 : 32'h5A5A5A5A, 1, "b_ld3");
`ifdef DMEM_RESPONDER_ALIGN_CHECK_EN
        op(1, 1'b0, 32'h12, 32'h0, 4'h0, 32'h0, 1, "b_ld12");
        chk("b_ld12_err", 32'(last_err), 32'd1);
`endif

        // LAT=15, base 0x1000: preload, below-base load, then random traffic vs model.
        for (int i = 0; i < 4; i++) begin
            model[i] = 32'h0101_0101 * (i + 1);
            op(2, 1'b1, 32'h1000 + 4 * i, model[i], 4'hF, 32'h0, 16, "c_pre");
        end
        op(2, 1'b0, 32'h0FFC, 32'h0, 4'h0, 32'h0, 16, "c_below");
        for (int t = 0; t < 10; t++) begin
            w_v = 1'($urandom_range(0, 1));
            idx = $urandom_range(0, 3);
            d_v = $urandom;
            b_v = 4'($urandom_range(0, 15));
            xact(2, w_v, 32'h1000 + 4 * idx, d_v, b_v, 1'b1, rd_v, cyc_v);
            chk("c_lat", 32'(cyc_v), 32'd16);
            if (w_v) begin
                for (int k = 0; k < 4; k++) begin
                    if (b_v[k]) model[idx][8*k +: 8] = d_v[8*k +: 8];
                end
                chk("c_st_rd", rd_v, 32'h0);
            end else begin
                chk("c_ld_rd", rd_v, model[idx]);
            end
        end

        // One response per accepted request; the reset-aborted request was accepted but not answered.
        repeat (2) @(negedge clk);
        chk("a_acc_cnt", 32'(acc_cnt[0]), 32'(issued[0] + 1));
        chk("a_rsp_cnt", 32'(rsp_cnt[0]), 32'(issued[0]));
        chk("b_acc_cnt", 32'(acc_cnt[1]), 32'(issued[1]));
        chk("b_rsp_cnt", 32'(rsp_cnt[1]), 32'(issued[1]));
        chk("c_acc_cnt", 32'(acc_cnt[2]), 32'(issued[2]));
        chk("c_rsp_cnt", 32'(rsp_cnt[2]), 32'(issued[2]));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
